load_store_queue: RTL

- Parametrised successor of the single-port in-order load/store buffer.
- Holds memory ops in program order between dispatch and the memory controller.
- Wakes operands from NUM_CDB broadcast channels, uses all DEPTH slots (count-based full), drives a valid/ready memory request register, blocks MMIO loads until non-speculative, and reports misaligned accesses to the ROB instead of issuing them.

---
 rtl/load_store_queue_pkg.sv | 27 ++
 rtl/lsq_entry_wakeup.sv | 52 +++++
 rtl/load_store_queue.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_queue_pkg.sv
// Shared constants, size encodings and CDB slicing helpers for the load/store queue.
package load_store_queue_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } mem_size_e;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h0003_0000;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SIZE_HALF: return addr_lo[0];
            SIZE_WORD: return addr_lo != 2'b00;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

`ifndef LSQ_PKG_MACROS
`define LSQ_PKG_MACROS
`define LSQ_TAG_READY(w) {(w){1'b1}}
`define LSQ_CDB_TAG(bus, ch, w) bus[(ch)*(w) +: (w)]
`define LSQ_CDB_DATA(bus, ch, w) bus[(ch)*(w) +: (w)]
`endif

// File: rtl/lsq_entry_wakeup.sv
// Compares one base/data tag pair against every CDB channel and returns the woken values.
module lsq_entry_wakeup #(
    parameter int ROB_W   = 4,
    parameter int XLEN    = 32,
    parameter int NUM_CDB = 2
) (
    input  logic [ROB_W:0]         q1,
    input  logic [XLEN-1:0]        addr,
    input  logic [ROB_W:0]         q2,
    input  logic [XLEN-1:0]        v2,
    input  logic [NUM_CDB-1:0]     cdb_valid,
    input  logic [NUM_CDB*ROB_W-1:0] cdb_tag,
    input  logic [NUM_CDB*XLEN-1:0]  cdb_data,
    output logic [ROB_W:0]         q1_new,
    output logic [XLEN-1:0]        addr_new,
    output logic [ROB_W:0]         q2_new,
    output logic [XLEN-1:0]        v2_new
);

    localparam logic [ROB_W:0] TAG_READY = `LSQ_TAG_READY(ROB_W+1);

    logic            hit1;
    logic            hit2;
    logic [XLEN-1:0] data1;
    logic [XLEN-1:0] data2;

    // NOTE: every output and temporary gets a default before any conditional
    // assignment, so this block can never infer a latch.
    always_comb begin
        hit1  = 1'b0;
        hit2  = 1'b0;
        data1 = '0;
        data2 = '0;
        // Scanning downward lets the lowest-numbered matching channel win.
        for (int ch = NUM_CDB - 1; ch >= 0; ch--) begin
            if (cdb_valid[ch] && q1 == {1'b0, `LSQ_CDB_TAG(cdb_tag, ch, ROB_W)}) begin
                hit1  = 1'b1;
                data1 = `LSQ_CDB_DATA(cdb_data, ch, XLEN);
            end
            if (cdb_valid[ch] && q2 == {1'b0, `LSQ_CDB_TAG(cdb_tag, ch, ROB_W)}) begin
                hit2  = 1'b1;
                data2 = `LSQ_CDB_DATA(cdb_data, ch, XLEN);
            end
        end

        q1_new   = hit1 ? TAG_READY : q1;
        addr_new = hit1 ? addr + data1 : addr;
        q2_new   = hit2 ? TAG_READY : q2;
        v2_new   = hit2 ? data2 : v2;
    end

endmodule

// File: rtl/load_store_queue.sv
// In-order load/store queue: CDB operand wakeup, MMIO gating, misalignment reporting,
// and a valid/ready memory request register.
module load_store_queue
    import load_store_queue_pkg::*;
#(
    parameter int              DEPTH     = 8,
    parameter int              XLEN      = 32,
    parameter int              ROB_W     = 4,
    parameter int              NUM_CDB   = 2,
    parameter logic [XLEN-1:0] MMIO_BASE = XLEN'(MMIO_BASE_DEFAULT)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     flush,
    input  logic                     enq_valid,
    output logic                     enq_ready,
    input  logic                     enq_is_store,
    input  logic [1:0]               enq_size,
    input  logic                     enq_unsigned,
    input  logic [ROB_W-1:0]         enq_rob_id,
    input  logic [ROB_W:0]           enq_q1,
    input  logic [XLEN-1:0]          enq_v1,
    input  logic [XLEN-1:0]          enq_imm,
    input  logic [ROB_W:0]           enq_q2,
    input  logic [XLEN-1:0]          enq_v2,
    input  logic [NUM_CDB-1:0]       cdb_valid,
    input  logic [NUM_CDB*ROB_W-1:0] cdb_tag,
    input  logic [NUM_CDB*XLEN-1:0]  cdb_data,
    input  logic [ROB_W-1:0]         rob_head_id,
    input  logic                     rob_store_commit,
    input  logic                     io_full,
    output logic                     front_valid,
    output logic                     front_is_store,
    output logic [ROB_W-1:0]         front_rob_id,
    output logic                     front_resolved,
    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic                     mem_req_we,
    output logic [1:0]               mem_req_size,
    output logic                     mem_req_unsigned,
    output logic [XLEN-1:0]          mem_req_addr,
    output logic [XLEN-1:0]          mem_req_wdata,
    output logic [ROB_W-1:0]         mem_req_rob_id,
    output logic                     exc_valid,
    output logic [ROB_W-1:0]         exc_rob_id,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int             PW        = $clog2(DEPTH);
    localparam int             TAG_W     = ROB_W + 1;
    localparam logic [TAG_W-1:0] TAG_READY = `LSQ_TAG_READY(TAG_W);

    typedef struct packed {
        logic             is_store;
        mem_size_e        size;
        logic             uns;
        logic [ROB_W-1:0] rob_id;
        logic [TAG_W-1:0] q1;
        logic [XLEN-1:0]  addr;
        logic [TAG_W-1:0] q2;
        logic [XLEN-1:0]  v2;
    } entry_t;

    entry_t        ent [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;

    // ---------------- enqueue-path wakeup ----------------
    logic [XLEN-1:0]  enq_addr_base;
    logic [TAG_W-1:0] enq_q1_w;
    logic [XLEN-1:0]  enq_addr_w;
    logic [TAG_W-1:0] enq_q2_w;
    logic [XLEN-1:0]  enq_v2_w;

    // An unready base starts from the offset alone; the base is added when it wakes.
    assign enq_addr_base = (enq_q1 == TAG_READY) ? enq_v1 + enq_imm : enq_imm;

    lsq_entry_wakeup #(.ROB_W(ROB_W), .XLEN(XLEN), .NUM_CDB(NUM_CDB)) u_enq_wakeup (
        .q1       (enq_q1),
        .addr     (enq_addr_base),
        .q2       (enq_q2),
        .v2       (enq_v2),
        .cdb_valid(cdb_valid),
        .cdb_tag  (cdb_tag),
        .cdb_data (cdb_data),
        .q1_new   (enq_q1_w),
        .addr_new (enq_addr_w),
        .q2_new   (enq_q2_w),
        .v2_new   (enq_v2_w)
    );

    // ---------------- per-entry wakeup ----------------
    logic [DEPTH-1:0] live;
    logic [TAG_W-1:0] wk_q1   [DEPTH];
    logic [XLEN-1:0]  wk_addr [DEPTH];
    logic [TAG_W-1:0] wk_q2   [DEPTH];
    logic [XLEN-1:0]  wk_v2   [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        logic [PW-1:0] slot_off;
        assign slot_off = PW'(g) - head;
        assign live[g]  = {1'b0, slot_off} < count;

        lsq_entry_wakeup #(.ROB_W(ROB_W), .XLEN(XLEN), .NUM_CDB(NUM_CDB)) u_wakeup (
            .q1       (ent[g].q1),
            .addr     (ent[g].addr),
            .q2       (ent[g].q2),
            .v2       (ent[g].v2),
            .cdb_valid(cdb_valid),
            .cdb_tag  (cdb_tag),
            .cdb_data (cdb_data),
            .q1_new   (wk_q1[g]),
            .addr_new (wk_addr[g]),
            .q2_new   (wk_q2[g]),
            .v2_new   (wk_v2[g])
        );
    end

    // ---------------- head decision ----------------
    entry_t h;
    logic   head_valid;
    logic   head_resolved;
    logic   head_misaligned;
    logic   out_free;
    logic   mmio_block;
    logic   load_issue;
    logic   store_issue;
    logic   exc_pop;
    logic   pop;
    logic   enq_fire;

    assign h               = ent[head];
    assign head_valid      = count != '0;
    assign head_resolved   = head_valid && h.q1 == TAG_READY && (!h.is_store || h.q2 == TAG_READY);
    assign head_misaligned = is_misaligned(h.size, h.addr[1:0]);
    assign out_free        = !mem_req_valid || mem_req_ready;
    assign mmio_block      = (h.addr >= MMIO_BASE) && (io_full || h.rob_id != rob_head_id);

    assign load_issue  = head_resolved && !h.is_store && !head_misaligned && out_free
                         && !mmio_block && !flush;
    // A committed store still leaves during a flush: it is architecturally done.
    assign store_issue = head_resolved && h.is_store && !head_misaligned && out_free
                         && rob_store_commit;
    assign exc_pop     = head_resolved && head_misaligned && !flush;
    assign pop         = load_issue || store_issue || exc_pop;
    assign enq_fire    = enq_valid && enq_ready && !flush;

    assign enq_ready      = count < ($clog2(DEPTH)+1)'(DEPTH);
    assign full           = count == ($clog2(DEPTH)+1)'(DEPTH);
    assign empty          = count == '0;
    assign front_valid    = head_valid;
    assign front_is_store = head_valid && h.is_store;
    assign front_rob_id   = head_valid ? h.rob_id : '0;
    assign front_resolved = head_resolved;

    // NOTE: only the tags are reset; payload fields are always written at
    // enqueue before anything can read them, so they need no reset.
    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            head             <= '0;
            tail             <= '0;
            count            <= '0;
            mem_req_valid    <= 1'b0;
            mem_req_we       <= 1'b0;
            mem_req_size     <= '0;
            mem_req_unsigned <= 1'b0;
            mem_req_addr     <= '0;
            mem_req_wdata    <= '0;
            mem_req_rob_id   <= '0;
            exc_valid        <= 1'b0;
            exc_rob_id       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent[i].q1 <= TAG_READY;
                ent[i].q2 <= TAG_READY;
            end
        end else if (rdy) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (live[i]) begin
                    ent[i].q1   <= wk_q1[i];
                    ent[i].addr <= wk_addr[i];
                    ent[i].q2   <= wk_q2[i];
                    ent[i].v2   <= wk_v2[i];
                end
            end

            if (enq_fire) begin
                ent[tail] <= '{is_store: enq_is_store,
                               size:     mem_size_e'(enq_size),
                               uns:      enq_unsigned,
                               rob_id:   enq_rob_id,
                               q1:       enq_q1_w,
                               addr:     enq_addr_w,
                               q2:       enq_is_store ? enq_q2_w : TAG_READY,
                               v2:       enq_v2_w};
            end

            if (pop) head <= head + 1'b1;

            if (flush) begin
                tail  <= head + PW'(store_issue);
                count <= '0;
            end else begin
                if (enq_fire) tail <= tail + 1'b1;
                case ({enq_fire, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: ;
                endcase
            end

            if (load_issue || store_issue) begin
                mem_req_valid    <= 1'b1;
                mem_req_we       <= h.is_store;
                mem_req_size     <= h.size;
                mem_req_unsigned <= h.uns;
                mem_req_addr     <= h.addr;
                mem_req_wdata    <= h.v2;
                mem_req_rob_id   <= h.rob_id;
            end else if (mem_req_ready || (flush && !mem_req_we)) begin
                mem_req_valid <= 1'b0;
            end

            exc_valid <= exc_pop;
            if (exc_pop) exc_rob_id <= h.rob_id;
        end
    end

endmodule
